// File: rtl/lmem_arbiter.sv
// ---------------------------------------------------------------------------
// lmem_arbiter
//
// Shares the single-port layer memory (L0/L1 banks selected by csel) between
// two requesters: port 0 is the conv engine, port 1 the max-pool engine.
// Ownership is round-robin. An owner may take up to MAX_BURST beats, after
// which it yields to a pending peer unless its lock input is high. Every
// memory control output comes from a register. Read data returns through a
// port-id tag pipeline, so each read goes back to the port that issued it.
//
// Ports
//   clk, reset          clock (rising edge); asynchronous active-low reset
//   req0/1, we0/1       access request; 1 = write, 0 = read
//   lock0/1             owner keeps the grant past MAX_BURST while high
//   addr0/1, wdata0/1   access address / write data
//   csel0/1             bank select that travels with the access
//   gnt0/1              registered grant
//   rvalid0/1, rdata    one-cycle read-return pulse per port, shared data
//   cwr, crd            memory write / read strobes
//   caddr_wr, cdata_wr  memory write address / data
//   caddr_rd, csel      memory read address / bank select
//   cdata_rd            memory read data, RD_LAT cycles after crd
//   state_dbg           current arbiter FSM state (IDLE=0, OWN0=1, OWN1=2)
//
// Handshake: a beat is accepted in any cycle where reqN and gntN are both 1.
// gntN depends only on registered state, so it never responds to reqN in the
// same cycle. If the owner drops req while granted, that cycle carries no
// beat and the grant falls on the next cycle. A later request is arbitrated
// again from IDLE.
// ---------------------------------------------------------------------------
module lmem_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 20,
  parameter int MAX_BURST = 16,
  parameter int RD_LAT    = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [2:0]    csel0,
  input  logic [2:0]    csel1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          cwr,
  output logic          crd,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [AW-1:0] caddr_rd,
  output logic [2:0]    csel,
  input  logic [DW-1:0] cdata_rd,
  output logic [1:0]    state_dbg
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          rr, rr_nxt;           // port preferred on the next contested IDLE
  logic [CW-1:0] beats, beats_nxt;     // beats accepted in the current ownership
  logic [CW-1:0] beats_inc;            // beats including this cycle's accept, saturating

  // Owner-side view of the inputs. In IDLE these show port 0, but accept
  // stays low there, so the values are never used.
  logic          own_sel;
  logic          sel_req, sel_we, sel_lock, other_req;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [2:0]    sel_csel;
  logic          accept;

  assign own_sel   = (state == OWN1);
  assign sel_req   = own_sel ? req1   : req0;
  assign sel_we    = own_sel ? we1    : we0;
  assign sel_lock  = own_sel ? lock1  : lock0;
  assign other_req = own_sel ? req0   : req1;
  assign sel_addr  = own_sel ? addr1  : addr0;
  assign sel_wdata = own_sel ? wdata1 : wdata0;
  assign sel_csel  = own_sel ? csel1  : csel0;
  assign accept    = (state != IDLE) && sel_req;

  assign gnt0      = (state == OWN0);
  assign gnt1      = (state == OWN1);
  assign state_dbg = state;

  assign beats_inc = (accept && (beats != BURST_MAX)) ? beats + CW'(1) : beats;

  // -------------------------------------------------------------------------
  // Arbitration FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rr    <= 1'b0;
      beats <= '0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
      beats <= beats_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    beats_nxt = beats;
    case (state)
      IDLE: begin
        // The counter clears here, so every new ownership starts at zero.
        beats_nxt = '0;
        if (req0 && req1) begin
          state_nxt = rr ? OWN1 : OWN0;
          rr_nxt    = ~rr;
        end else if (req0) begin
          state_nxt = OWN0;
          rr_nxt    = 1'b1;
        end else if (req1) begin
          state_nxt = OWN1;
          rr_nxt    = 1'b0;
        end
      end
      OWN0, OWN1: begin
        beats_nxt = beats_inc;
        // The limit test includes the current beat. The beat that reaches
        // MAX_BURST is therefore the last one, and the owner never takes an
        // extra beat before the grant falls.
        if (!sel_req) begin
          state_nxt = IDLE;
        end else if ((beats_inc == BURST_MAX) && other_req && !sel_lock) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Memory command registers: issued one cycle after the accept
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cwr      <= 1'b0;
      crd      <= 1'b0;
      csel     <= 3'd0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      caddr_rd <= '0;
    end else begin
      cwr  <= accept && sel_we;
      crd  <= accept && !sel_we;
      csel <= accept ? sel_csel : 3'd0;
      // Addresses and write data hold between accesses, so the buses
      // do not toggle while idle.
      if (accept && sel_we) begin
        caddr_wr <= sel_addr;
        cdata_wr <= sel_wdata;
      end
      if (accept && !sel_we) begin
        caddr_rd <= sel_addr;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read-return tag pipeline
  // Stage 0 lines up with crd. Stage RD_LAT lines up with valid cdata_rd.
  // The port id travels with each read, so a return after a handover still
  // reaches the port that issued it.
  // -------------------------------------------------------------------------
  logic [RD_LAT:0] tag_v;
  logic [RD_LAT:0] tag_p;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_v <= '0;
      tag_p <= '0;
    end else begin
      tag_v[0] <= accept && !sel_we;
      tag_p[0] <= own_sel;
      for (int i = 1; i <= RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
    end else begin
      rvalid0 <= tag_v[RD_LAT] && !tag_p[RD_LAT];
      rvalid1 <= tag_v[RD_LAT] &&  tag_p[RD_LAT];
      if (tag_v[RD_LAT]) begin
        rdata <= cdata_rd;
      end
    end
  end

endmodule

// File: tb/tb_lmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lmem_arbiter
// Directed checks of lmem_arbiter with a read-only memory model (RD_LAT=1).
// Memory contents are a fixed function of the address: mem_val(a) = {A5, a}.
// Expected values below are hand-computed cycle by cycle.
// ---------------------------------------------------------------------------
module tb_lmem_arbiter;
  localparam int AW = 12;
  localparam int DW = 20;
  localparam int MAX_BURST = 16;

  logic          clk;
  logic          reset;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [2:0]    csel0, csel1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          cwr, crd;
  logic [AW-1:0] caddr_wr, caddr_rd;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;
  logic [DW-1:0] cdata_rd;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  lmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .csel0(csel0), .csel1(csel1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .cwr(cwr), .crd(crd),
    .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .caddr_rd(caddr_rd),
    .csel(csel), .cdata_rd(cdata_rd), .state_dbg(state_dbg)
  );

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return {8'hA5, a};
  endfunction

  // Memory model: one registered stage, so data appears the cycle after crd.
  always @(posedge clk) begin
    if (crd) cdata_rd <= mem_val(caddr_rd);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; csel0 = '0; csel1 = '0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},    32'({gnt1, gnt0}), 0);
    check({tag, "_rvalid"}, 32'({rvalid1, rvalid0}), 0);
    check({tag, "_strobe"}, 32'({cwr, crd}), 0);
    check({tag, "_csel"},   32'(csel), 0);
    check({tag, "_caddrwr"},32'(caddr_wr), 0);
    check({tag, "_cdatawr"},32'(cdata_wr), 0);
    check({tag, "_caddrrd"},32'(caddr_rd), 0);
    check({tag, "_rdata"},  32'(rdata), 0);
    check({tag, "_state"},  32'(state_dbg), 0);
  endtask

  // Holds reset for two cycles, checks the reset state, then releases reset
  // just after a clock edge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    drive_idle();
    tick();
    tick();
    check_all_zero(tag);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] rd_addrs [4];
    int acc;
    rd_addrs[0] = 12'd0; rd_addrs[1] = 12'd1; rd_addrs[2] = 12'd64; rd_addrs[3] = 12'd65;
    reset = 1'b0;
    drive_idle();

    // T1: single write from port 0
    do_reset("t1_rst");
    req0 = 1; we0 = 1; addr0 = 12'h005; wdata0 = 20'h01310; csel0 = 3'd1;
    tick();                                        // c1: grant visible
    check("t1_gnt0", 32'(gnt0), 1);
    check("t1_gnt1", 32'(gnt1), 0);
    tick();                                        // c2: command from c1 accept
    check("t1_cwr", 32'(cwr), 1);
    check("t1_crd", 32'(crd), 0);
    check("t1_caddr_wr", 32'(caddr_wr), 32'h005);
    check("t1_cdata_wr", 32'(cdata_wr), 32'h01310);
    check("t1_csel", 32'(csel), 1);
    req0 = 0;
    tick();                                        // c3: no accept in c2
    check("t1_gnt_drop", 32'({gnt1, gnt0}), 0);
    check("t1_cwr_idle", 32'(cwr), 0);
    check("t1_csel_idle", 32'(csel), 0);
    check("t1_caddr_hold", 32'(caddr_wr), 32'h005);

    // T2: simultaneous requests from reset, port 0 wins, one idle gap
    do_reset("t2_rst");
    req0 = 1; we0 = 1; addr0 = 12'h030; wdata0 = 20'h11111; csel0 = 3'd2;
    req1 = 1; we1 = 1; addr1 = 12'h040; wdata1 = 20'h22222; csel1 = 3'd3;
    tick();
    check("t2_first_gnt", 32'({gnt1, gnt0}), 32'b01);
    tick();
    check("t2_cdata_wr0", 32'(cdata_wr), 32'h11111);
    check("t2_csel0", 32'(csel), 2);
    req0 = 0;
    tick();
    check("t2_idle_gap", 32'({gnt1, gnt0}), 0);
    tick();
    check("t2_second_gnt", 32'({gnt1, gnt0}), 32'b10);
    tick();
    check("t2_caddr_wr1", 32'(caddr_wr), 32'h040);
    check("t2_csel1", 32'(csel), 3);
    req1 = 0;
    tick();
    tick();

    // T3: port 1 back-to-back reads, returns at accept+3 in order
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(mem_val(rd_addrs[k]));
    req1 = 1; we1 = 0; addr1 = rd_addrs[0];
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("t3_crd", 32'(crd), 32'(i >= 2 && i <= 5));
      check("t3_rvalid1", 32'(rvalid1), 32'(i >= 4 && i <= 7));
      check("t3_rvalid0", 32'(rvalid0), 0);
      if (i >= 4 && i <= 7 && exp_q.size() > 0) check("t3_rdata", 32'(rdata), 32'(exp_q.pop_front()));
      if (i <= 4) addr1 = rd_addrs[i-1];
      else req1 = 0;
    end
    check("t3_queue_empty", exp_q.size(), 0);

    // T4: burst limit, then lock
    do_reset("t4_rst");
    req0 = 1; we0 = 1; addr0 = 12'h010; wdata0 = 20'h0AAAA;
    req1 = 1; we1 = 1; addr1 = 12'h020; wdata1 = 20'h0BBBB;
    acc = 0;
    for (int i = 1; i <= 18; i++) begin
      tick();
      check("t4_excl", 32'(gnt0 & gnt1), 0);
      if (gnt0 && req0) acc++;
      if (i == 17) check("t4_gap", 32'({gnt1, gnt0}), 0);
      if (i == 18) check("t4_handover", 32'({gnt1, gnt0}), 32'b10);
    end
    check("t4_accepts", acc, MAX_BURST);
    req1 = 0;
    tick();
    check("t4_back_idle", 32'({gnt1, gnt0}), 0);
    tick();
    check("t4_regrant0", 32'({gnt1, gnt0}), 32'b01);
    lock0 = 1; req1 = 1;
    for (int i = 0; i < 24; i++) begin
      tick();
      check("t4_lock_hold", 32'({gnt1, gnt0}), 32'b01);
    end
    lock0 = 0;
    tick();
    check("t4_unlock_drop", 32'({gnt1, gnt0}), 0);
    tick();
    check("t4_unlock_gnt1", 32'({gnt1, gnt0}), 32'b10);

    // T5: port 1 read returns while port 0 already owns the memory
    do_reset("t5_rst");
    req1 = 1; we1 = 0; addr1 = 12'd64;
    tick();
    check("t5_gnt1", 32'({gnt1, gnt0}), 32'b10);
    req0 = 1; we0 = 1; addr0 = 12'h100; wdata0 = 20'h0CCCC;
    tick();
    req1 = 0;
    tick();
    check("t5_gap", 32'({gnt1, gnt0}), 0);
    check("t5_no_early_rvalid", 32'({rvalid1, rvalid0}), 0);
    tick();
    check("t5_gnt0", 32'({gnt1, gnt0}), 32'b01);
    check("t5_rvalid_tag", 32'({rvalid1, rvalid0}), 32'b10);
    check("t5_rdata", 32'(rdata), 32'(mem_val(12'd64)));
    tick();
    check("t5_rvalid_pulse", 32'({rvalid1, rvalid0}), 0);

    // T6: asynchronous reset with a read in flight
    do_reset("t6_rst");
    req1 = 1; we1 = 0; addr1 = 12'd1;
    tick();
    check("t6_gnt1", 32'(gnt1), 1);
    tick();
    check("t6_crd", 32'(crd), 1);
    reset = 1'b0;
    req0 = 1; we0 = 1;
    #1;
    check_all_zero("t6_async");
    tick();
    tick();
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("t6_no_rvalid", 32'({rvalid1, rvalid0}), 0);
      if (i == 1) check("t6_post_gnt", 32'({gnt1, gnt0}), 32'b01);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
